// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel, W-bit round-robin arbitrating mux with one
// registered output stage and optional packet locking.
//
// Lock FSM
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_OPEN   | no packet in flight; grant follows round-robin search
//   ST_LOCKED | a packet is mid-flight on lock_ch_q; grant is pinned
//             | there until that channel transfers its last beat
module rr_arb_mux #(
  parameter int _W    = 32,
  parameter int _N    = 4,
  parameter int _S    = (_N > 1) ? $clog2(_N) : 1,
  parameter int _LOCK = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [_W-1:0] in_data [_N],
  input  logic [_N-1:0] in_valid,
  input  logic [_N-1:0] in_last,
  output logic [_N-1:0] in_ready,
  output logic [_W-1:0] out_data,
  output logic          out_last,
  output logic [_S-1:0] out_src,
  output logic          out_valid,
  input  logic          out_ready
);

  // One extra bit so ptr + offset can exceed _N-1 before the wrap.
  localparam int SW = _S + 1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e   state_q, state_d;
  logic [_S-1:0] lock_ch_q, lock_ch_d;
  logic [_S-1:0] ptr_q, ptr_d;
  logic [_W-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic [_S-1:0] src_q, src_d;
  logic          valid_q, valid_d;

  logic          ld;
  logic          locked;
  logic          found;
  logic [SW-1:0] cand;
  logic [_S-1:0] arb_idx;
  logic [_S-1:0] grant;
  logic [_S-1:0] grant_inc;
  logic          xfer;

  // The output slot can take a beat when empty or being drained this cycle.
  assign ld     = !valid_q | out_ready;
  assign locked = (state_q == ST_LOCKED);

  // Round-robin search: first valid channel starting at ptr, wrapping at _N.
  always_comb begin
    found   = 1'b0;
    arb_idx = ptr_q;
    cand    = '0;
    for (int k = 0; k < _N; k++) begin
      cand = {1'b0, ptr_q} + SW'(k);
      if (cand >= SW'(_N)) begin
        cand = cand - SW'(_N);
      end
      if (!found && in_valid[cand[_S-1:0]]) begin
        found   = 1'b1;
        arb_idx = cand[_S-1:0];
      end
    end
  end

  assign grant     = locked ? lock_ch_q : arb_idx;
  assign grant_inc = (grant == _S'(_N - 1)) ? '0 : grant + _S'(1);

  // Ready goes only to the granted channel; held low throughout reset.
  always_comb begin
    in_ready        = '0;
    in_ready[grant] = rst_n & ld & (locked | in_valid[grant]);
  end

  assign xfer = in_valid[grant] & in_ready[grant];

  // Lock FSM next state: a non-last beat pins the channel, a last beat frees it.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ST_OPEN: begin
        if (xfer && !in_last[grant] && (_LOCK != 0)) begin
          state_d   = ST_LOCKED;
          lock_ch_d = grant;
        end
      end
      ST_LOCKED: begin
        if (xfer && in_last[grant]) begin
          state_d = ST_OPEN;
        end
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase
  end

  // Pointer moves past the winner at packet boundaries (every beat when unlocked mode).
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && ((_LOCK == 0) || in_last[grant])) begin
      ptr_d = grant_inc;
    end
  end

  // Output slot: load on transfer, empty on an idle load, hold under backpressure.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    src_d   = src_q;
    valid_d = valid_q;
    if (ld) begin
      if (xfer) begin
        data_d  = in_data[grant];
        last_d  = in_last[grant];
        src_d   = grant;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; async reset drops any held beat and any lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OPEN;
      lock_ch_q <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      src_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      src_q     <= src_d;
      valid_q   <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed bench for rr_arb_mux. Two instances: u4 (4 ch,
// locking) and u3 (3 ch, no locking). Expected beats are queued when
// stimulus is issued; a negedge monitor pops them as the DUT delivers.
module tb_rr_arb_mux;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  beat_t q4[$];
  beat_t q3[$];

  logic [31:0] d4 [4];
  logic [3:0]  v4, l4, rdy4;
  logic [31:0] od4;
  logic        ol4, ov4, ordy4;
  logic [1:0]  os4;

  logic [31:0] d3 [3];
  logic [2:0]  v3, l3, rdy3;
  logic [31:0] od3;
  logic        ol3, ov3, ordy3;
  logic [1:0]  os3;

  rr_arb_mux #(._W(32), ._N(4), ._LOCK(1)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d4), .in_valid(v4), .in_last(l4), .in_ready(rdy4),
    .out_data(od4), .out_last(ol4), .out_src(os4), .out_valid(ov4),
    .out_ready(ordy4)
  );

  rr_arb_mux #(._W(32), ._N(3), ._LOCK(0)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d3), .in_valid(v3), .in_last(l3), .in_ready(rdy3),
    .out_data(od3), .out_last(ol3), .out_src(os3), .out_valid(ov3),
    .out_ready(ordy3)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic beat_t mk(int s, logic [31:0] d, logic l);
    beat_t b;
    b.src  = 2'(s);
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every accepted output beat must match the head of its queue.
  always @(negedge clk) begin
    beat_t e4, e3;
    if (rst_n && ov4 && ordy4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u4_unexpected_beat: got src %0d data %0h, expected no beat", os4, od4);
      end else begin
        e4 = q4.pop_front();
        chk("u4_src", os4, e4.src);
        chk("u4_data", od4, e4.data);
        chk("u4_last", ol4, e4.last);
      end
    end
    if (rst_n && ov3 && ordy3) begin
      chk("u3_src_range", os3 < 2'd3, 1'b1);
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u3_unexpected_beat: got src %0d data %0h, expected no beat", os3, od3);
      end else begin
        e3 = q3.pop_front();
        chk("u3_src", os3, e3.src);
        chk("u3_data", od3, e3.data);
        chk("u3_last", ol3, e3.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) d4[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) d3[i] = '0;
    v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
    v3 = '0;      l3 = '0;      ordy3 = 1'b1;

    // Reset state, with every channel valid to show in_ready is forced low.
    at_neg();
    at_neg();
    chk("rst_out_valid", ov4, 1'b0);
    chk("rst_out_data", od4, 32'h0);
    chk("rst_out_last", ol4, 1'b0);
    chk("rst_out_src", os4, 2'd0);
    chk("rst_in_ready", rdy4, 4'b0000);

    // All valid, last=1: rotating grant 0,1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      drive_pt();
      if (k == 0) rst_n = 1'b1;
      q4.push_back(mk(k % 4, 32'h1000_0000 + 32'(k % 4), 1'b1));
      at_neg();
      chk("rr_in_ready", rdy4, 4'b0001 << (k % 4));
      if (k > 0) chk("rr_out_valid", ov4, 1'b1);
    end
    drive_pt();
    v4 = 4'b0000;
    at_neg();

    // Lock: ch1 sends 3 beats while ch2 waits with 0xA5.
    drive_pt();
    v4 = 4'b0110; l4 = 4'b0100; d4[1] = 32'hB1; d4[2] = 32'hA5;
    q4.push_back(mk(1, 32'hB1, 1'b0));
    at_neg();
    chk("lock_b1_ready", rdy4, 4'b0010);
    drive_pt();
    d4[1] = 32'hB2;
    q4.push_back(mk(1, 32'hB2, 1'b0));
    at_neg();
    chk("lock_b2_ready", rdy4, 4'b0010);
    drive_pt();
    d4[1] = 32'hB3; l4 = 4'b0110;
    q4.push_back(mk(1, 32'hB3, 1'b1));
    at_neg();
    chk("lock_b3_ready", rdy4, 4'b0010);
    drive_pt();
    v4 = 4'b0100;
    q4.push_back(mk(2, 32'hA5, 1'b1));
    at_neg();
    chk("lock_ch2_ready", rdy4, 4'b0100);
    drive_pt();
    v4 = 4'b0000;
    at_neg();

    // Locked channel stalls while ch0 stays valid; ptr now 3.
    drive_pt();
    v4 = 4'b1001; l4 = 4'b0001; d4[3] = 32'hC1; d4[0] = 32'hD0;
    q4.push_back(mk(3, 32'hC1, 1'b0));
    at_neg();
    chk("stall_first_ready", rdy4, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      drive_pt();
      v4 = 4'b0001;
      at_neg();
      chk("stall_in_ready", rdy4, 4'b1000);
      if (k > 0) chk("stall_out_valid", ov4, 1'b0);
    end
    drive_pt();
    v4 = 4'b1001; l4 = 4'b1001; d4[3] = 32'hC2;
    q4.push_back(mk(3, 32'hC2, 1'b1));
    at_neg();
    chk("stall_resume_ready", rdy4, 4'b1000);
    drive_pt();
    v4 = 4'b0001;
    q4.push_back(mk(0, 32'hD0, 1'b1));
    at_neg();
    chk("stall_after_ready", rdy4, 4'b0001);
    drive_pt();
    v4 = 4'b0000;
    at_neg();

    // Backpressure: 0x1234 held for 5 cycles, then 0x5678 follows; ptr now 1.
    drive_pt();
    v4 = 4'b0010; l4 = 4'b1111; d4[1] = 32'h1234; d4[2] = 32'h5678;
    q4.push_back(mk(1, 32'h1234, 1'b1));
    at_neg();
    for (int k = 0; k < 5; k++) begin
      drive_pt();
      v4 = 4'b0100; ordy4 = 1'b0;
      at_neg();
      chk("bp_out_data", od4, 32'h1234);
      chk("bp_out_valid", ov4, 1'b1);
      chk("bp_in_ready", rdy4, 4'b0000);
    end
    drive_pt();
    ordy4 = 1'b1;
    q4.push_back(mk(2, 32'h5678, 1'b1));
    at_neg();
    chk("bp_release_ready", rdy4, 4'b0100);
    drive_pt();
    v4 = 4'b0000;
    at_neg();
    chk("bp_next_valid", ov4, 1'b1);

    // Async reset mid-packet on ch3 (ptr now 3).
    drive_pt();
    v4 = 4'b1000; l4 = 4'b0000; d4[3] = 32'hE1;
    q4.push_back(mk(3, 32'hE1, 1'b0));
    at_neg();
    chk("rstmid_ready", rdy4, 4'b1000);
    drive_pt();
    v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", ov4, 1'b0);
    chk("rstmid_in_ready", rdy4, 4'b0000);
    q4.delete();
    drive_pt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 32'h2000_0000 + 32'(i);
    q4.push_back(mk(0, 32'h2000_0000, 1'b1));
    at_neg();
    chk("rstmid_restart_ready", rdy4, 4'b0001);
    drive_pt();
    v4 = 4'b0000;
    at_neg();

    // Three channels, no locking: ch2 then wrap to ch0.
    d3[0] = 32'h30; d3[1] = 32'h31; d3[2] = 32'h22;
    drive_pt();
    v3 = 3'b100; l3 = 3'b000;
    q3.push_back(mk(2, 32'h22, 1'b0));
    at_neg();
    chk("n3_ready_c0", rdy3, 3'b100);
    drive_pt();
    v3 = 3'b101; l3 = 3'b001; d3[2] = 32'h23;
    q3.push_back(mk(0, 32'h30, 1'b1));
    at_neg();
    chk("n3_ready_c1", rdy3, 3'b001);
    drive_pt();
    v3 = 3'b111; l3 = 3'b011;
    q3.push_back(mk(1, 32'h31, 1'b1));
    at_neg();
    chk("n3_ready_c2", rdy3, 3'b010);
    drive_pt();
    v3 = 3'b100;
    q3.push_back(mk(2, 32'h23, 1'b0));
    at_neg();
    chk("n3_ready_c3", rdy3, 3'b100);
    drive_pt();
    v3 = 3'b001;
    q3.push_back(mk(0, 32'h30, 1'b1));
    at_neg();
    chk("n3_ready_c4", rdy3, 3'b001);
    drive_pt();
    v3 = 3'b000;
    at_neg();

    drive_pt();
    at_neg();
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
